// File: rtl/vic_prio_sched_if.sv
// Handshake and status bundle between vic_prio_sched and its neighbours.
// The master modport is the scheduler side; slave is the line-qualifier/vic_ctrl side.
interface vic_prio_sched_if #(
    parameter int unsigned N_IRQ = 31,
    parameter int unsigned PW    = 2
);
    logic                en;
    logic [N_IRQ-1:0]    req;
    logic [N_IRQ*PW-1:0] prio;
    logic                ack;
    logic                reti;
    logic                irq;
    logic [4:0]          irq_addr;
    logic [4:0]          active;
    logic [2:0]          depth;
    logic                reti_err;

    modport master (
        input  en, req, prio, ack, reti,
        output irq, irq_addr, active, depth, reti_err
    );

    modport slave (
        output en, req, prio, ack, reti,
        input  irq, irq_addr, active, depth, reti_err
    );
endinterface

// File: rtl/vic_prio_sched.sv
// Priority scheduler: latches requests, offers the most urgent one to vic_ctrl, tracks nesting.
// Define VIC_NEST_EN to allow preemption up to DEPTH levels; otherwise one ISR at a time.
module vic_prio_sched #(
    parameter int unsigned N_IRQ = 31,
    parameter int unsigned PW    = 2,
    parameter int unsigned DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    vic_prio_sched_if.master bus
);
`ifdef VIC_NEST_EN
    localparam int unsigned EFF_DEPTH = DEPTH;
`else
    localparam int unsigned EFF_DEPTH = 1;
`endif
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e                     state_q, state_d;
    logic [N_IRQ-1:0]           pend_q, pend_d;
    logic [4:0]                 offer_id_q, offer_id_d;
    logic [PW-1:0]              offer_prio_q, offer_prio_d;
    logic [DEPTH-1:0][PW-1:0]   stk_prio_q, stk_prio_d;
    logic [DEPTH-1:0][4:0]      stk_id_q, stk_id_d;
    logic [DW-1:0]              depth_q, depth_d;
    logic                       reti_err_q, reti_err_d;

    logic [PW-1:0]    top_prio;
    logic [4:0]       top_id;
    logic [N_IRQ-1:0] cand;
    logic             found;
    logic [4:0]       sel_id;
    logic [PW-1:0]    sel_prio;
    logic             push;
    logic             pop;
    logic [DW-1:0]    depth_pop;

    always_comb begin
        top_prio = '0;
        top_id   = '0;
        if (depth_q != '0) begin
            top_prio = stk_prio_q[SW'(depth_q - 1'b1)];
            top_id   = stk_id_q[SW'(depth_q - 1'b1)];
        end
    end

    // Requests arriving this cycle are eligible immediately, giving one-cycle offer latency.
    always_comb begin
        cand     = pend_q | bus.req;
        found    = 1'b0;
        sel_id   = '0;
        sel_prio = '0;
        for (int n = 0; n < N_IRQ; n++) begin
            if (cand[n] && ((depth_q == '0) || (bus.prio[n*PW +: PW] > top_prio)) &&
                (!found || (bus.prio[n*PW +: PW] > sel_prio))) begin
                found    = 1'b1;
                sel_id   = 5'(n + 1);
                sel_prio = bus.prio[n*PW +: PW];
            end
        end
        if (depth_q >= DW'(EFF_DEPTH)) begin
            found = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        offer_id_d   = offer_id_q;
        offer_prio_d = offer_prio_q;
        push         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.en && found) begin
                    state_d      = StReq;
                    offer_id_d   = sel_id;
                    offer_prio_d = sel_prio;
                end
            end
            StReq: begin
                if (bus.ack) begin
                    push    = 1'b1;
                    state_d = StHold;
                end else if (!bus.en) begin
                    state_d = StIdle;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A new request on the line being acknowledged keeps it pending.
    always_comb begin
        pend_d = pend_q;
        if (push) begin
            pend_d[offer_id_q - 5'd1] = 1'b0;
        end
        pend_d = pend_d | bus.req;
    end

    // Pop is applied before push so a same-cycle ack and reti replaces the top entry.
    always_comb begin
        pop        = bus.reti && (depth_q != '0);
        reti_err_d = bus.reti && (depth_q == '0);
        stk_prio_d = stk_prio_q;
        stk_id_d   = stk_id_q;
        depth_pop  = depth_q - DW'(pop);
        depth_d    = depth_pop;
        if (push && (depth_pop < DW'(DEPTH))) begin
            stk_prio_d[SW'(depth_pop)] = offer_prio_q;
            stk_id_d[SW'(depth_pop)]   = offer_id_q;
            depth_d                    = depth_pop + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            offer_id_q   <= '0;
            offer_prio_q <= '0;
            stk_prio_q   <= '0;
            stk_id_q     <= '0;
            depth_q      <= '0;
            reti_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            offer_id_q   <= offer_id_d;
            offer_prio_q <= offer_prio_d;
            stk_prio_q   <= stk_prio_d;
            stk_id_q     <= stk_id_d;
            depth_q      <= depth_d;
            reti_err_q   <= reti_err_d;
        end
    end

    assign bus.irq      = (state_q == StReq);
    assign bus.irq_addr = (state_q == StReq) ? offer_id_q : 5'd0;
    assign bus.active   = top_id;
    assign bus.depth    = 3'(depth_q);
    assign bus.reti_err = reti_err_q;
endmodule

// File: tb/tb_vic_prio_sched.sv
// Bench for vic_prio_sched: directed vector table, hand sequences for nesting/reset,
// then randomized traffic against a queue-based reference model.
module tb_vic_prio_sched;
    localparam int unsigned N_IRQ = 31;
    localparam int unsigned PW    = 2;
    localparam int unsigned DEPTH = 4;
`ifdef VIC_NEST_EN
    localparam int EFF = DEPTH;
`else
    localparam int EFF = 1;
`endif

    typedef logic [N_IRQ*PW-1:0] prio_t;
    typedef logic [N_IRQ-1:0]    req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vic_prio_sched_if #(.N_IRQ(N_IRQ), .PW(PW)) bus ();

    vic_prio_sched #(.N_IRQ(N_IRQ), .PW(PW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       en;
        req_t       req;
        logic       ack;
        logic       reti;
        logic       irq;
        logic [4:0] addr;
        logic [4:0] act;
        logic [2:0] dep;
        logic       err;
    } vec_t;
    vec_t tbl[$];

    typedef struct {
        int p;
        int id;
    } ent_t;
    ent_t mstk[$];
    bit   mpend[N_IRQ];
    int   moffer, mofferp;
    bit   mhold, merr;

    function automatic prio_t pr(int line, int p);
        prio_t v = '0;
        v[line*PW +: PW] = PW'(p);
        return v;
    endfunction

    function automatic req_t rb(int n);
        req_t v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic add(string name, logic en, req_t req, logic ack, logic reti, logic irq,
                       int addr, int act, int dep, logic err);
        vec_t v;
        v.name = name; v.en = en; v.req = req; v.ack = ack; v.reti = reti;
        v.irq = irq; v.addr = 5'(addr); v.act = 5'(act); v.dep = 3'(dep); v.err = err;
        tbl.push_back(v);
    endtask

    task automatic drive(logic en, req_t req, prio_t prio, logic ack, logic reti);
        bus.en   = en;
        bus.req  = req;
        bus.prio = prio;
        bus.ack  = ack;
        bus.reti = reti;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic irq, int addr, int act, int dep, logic err);
        checks++;
        if (bus.irq !== irq || bus.irq_addr !== 5'(addr) || bus.active !== 5'(act) ||
            bus.depth !== 3'(dep) || bus.reti_err !== err) begin
            errors++;
            $display("FAIL %s: got irq=%0b addr=%0d active=%0d depth=%0d reti_err=%0b; want irq=%0b addr=%0d active=%0d depth=%0d reti_err=%0b",
                     name, bus.irq, bus.irq_addr, bus.active, bus.depth, bus.reti_err,
                     irq, addr, act, dep, err);
        end
    endtask

    // Reference model: highest prio above the in-service threshold, lowest index on ties.
    function automatic int pick(req_t req, prio_t prio, output int bp);
        int thr  = (mstk.size() > 0) ? mstk[$].p : -1;
        int best = 0;
        bp = -1;
        if (mstk.size() >= EFF) return 0;
        for (int n = 0; n < N_IRQ; n++) begin
            int p = int'(prio[n*PW +: PW]);
            if ((mpend[n] || req[n]) && p > thr && p > bp) begin
                best = n + 1;
                bp   = p;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        foreach (mpend[n]) mpend[n] = 1'b0;
        mstk.delete();
        moffer = 0; mofferp = 0; mhold = 1'b0; merr = 1'b0;
    endtask

    task automatic model_step(logic en, req_t req, prio_t prio, logic ack, logic reti);
        int   nid = 0;
        int   np  = 0;
        bit   taken = 1'b0;
        ent_t e;
        if (moffer != 0) begin
            if (ack) taken = 1'b1;
            else if (en) nid = moffer;
        end else if (!mhold && en) begin
            nid = pick(req, prio, np);
        end
        for (int n = 0; n < N_IRQ; n++) begin
            if (req[n]) mpend[n] = 1'b1;
            else if (taken && n == moffer - 1) mpend[n] = 1'b0;
        end
        merr = reti && (mstk.size() == 0);
        if (reti && mstk.size() > 0) void'(mstk.pop_back());
        if (taken) begin
            e.p = mofferp; e.id = moffer;
            mstk.push_back(e);
        end
        if (nid != 0 && moffer == 0) mofferp = np;
        moffer = nid;
        mhold  = taken;
    endtask

    initial begin
        prio_t p_tbl, p3, p6, pd, r_prio;
        req_t  r_req;
        logic  r_en, r_ack, r_reti;

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        p_tbl = pr(4, 1) | pr(2, 2) | pr(7, 2) | pr(9, 3);
        add("t1_req",        1, rb(4), 0, 0, 1, 5, 0, 0, 0);
        add("t1_held",       1, '0,    0, 0, 1, 5, 0, 0, 0);
        add("t1_ack",        1, '0,    1, 0, 0, 0, 5, 1, 0);
        add("t1_hold",       1, '0,    0, 0, 0, 0, 5, 1, 0);
        add("t1_reti",       1, '0,    0, 1, 0, 0, 0, 0, 0);
        add("t2_req",        1, rb(2) | rb(7) | rb(9), 0, 0, 1, 10, 0, 0, 0);
        add("t2_ack",        1, '0,    1, 0, 0, 0, 10, 1, 0);
        add("t2_reti",       1, '0,    0, 1, 0, 0, 0, 0, 0);
        add("t2_tie",        1, '0,    0, 0, 1, 3, 0, 0, 0);
        add("t2_ack2",       1, '0,    1, 0, 0, 0, 3, 1, 0);
        add("t2_reti2",      1, '0,    0, 1, 0, 0, 0, 0, 0);
        add("t4_offer",      1, '0,    0, 0, 1, 8, 0, 0, 0);
        add("t4_drop",       0, '0,    0, 0, 0, 0, 0, 0, 0);
        add("t4_off",        0, '0,    0, 0, 0, 0, 0, 0, 0);
        add("t4_reen",       1, '0,    0, 0, 1, 8, 0, 0, 0);
        add("t4_ack",        1, '0,    1, 0, 0, 0, 8, 1, 0);
        add("t5_pop",        1, '0,    0, 1, 0, 0, 0, 0, 0);
        add("t5_err",        1, '0,    0, 1, 0, 0, 0, 0, 1);
        add("t5_errclr",     1, '0,    0, 0, 0, 0, 0, 0, 0);
        add("ack_idle",      0, '0,    1, 0, 0, 0, 0, 0, 0);
        add("ackreti_req",   1, rb(4), 0, 0, 1, 5, 0, 0, 0);
        add("ackreti_empty", 1, '0,    1, 1, 0, 0, 5, 1, 1);
        add("ackreti_pop",   1, '0,    0, 1, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].req, p_tbl, tbl[i].ack, tbl[i].reti);
            tick();
            check(tbl[i].name, tbl[i].irq, int'(tbl[i].addr), int'(tbl[i].act),
                  int'(tbl[i].dep), tbl[i].err);
        end

        // Asynchronous reset in the middle of an offer.
        drive(1'b1, rb(3), p_tbl, 1'b0, 1'b0);
        tick();
        check("rst_pre", 1, 4, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 0, 0, 0, 0, 0);
        drive(1'b0, '0, p_tbl, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, '0, p_tbl, 1'b0, 1'b0);
        tick();
        check("rst_pend_clr", 0, 0, 0, 0, 0);

`ifdef VIC_NEST_EN
        p3 = pr(0, 1) | pr(3, 2) | pr(5, 2);
        drive(1, rb(0), p3, 0, 0); tick(); check("t3_offer1", 1, 1, 0, 0, 0);
        drive(1, '0,    p3, 1, 0); tick(); check("t3_ack1",   0, 0, 1, 1, 0);
        drive(1, rb(3), p3, 0, 0); tick(); check("t3_hold1",  0, 0, 1, 1, 0);
        drive(1, '0,    p3, 0, 0); tick(); check("t3_preempt", 1, 4, 1, 1, 0);
        drive(1, rb(5), p3, 1, 0); tick(); check("t3_ack2",   0, 0, 4, 2, 0);
        drive(1, '0,    p3, 0, 0); tick(); check("t3_hold2",  0, 0, 4, 2, 0);
        tick();                            check("t3_eq_blk", 0, 0, 4, 2, 0);
        drive(1, '0,    p3, 0, 1); tick(); check("t3_reti",   0, 0, 1, 1, 0);
        drive(1, '0,    p3, 0, 0); tick(); check("t3_offer6", 1, 6, 1, 1, 0);
        drive(1, '0,    p3, 1, 1); tick(); check("t5_ack_reti", 0, 0, 6, 1, 0);
        drive(1, '0,    p3, 0, 1); tick(); check("t3_drain",  0, 0, 0, 0, 0);

        p6 = pr(10, 0) | pr(11, 1) | pr(12, 2) | pr(13, 3) | pr(14, 3);
        for (int k = 0; k < 4; k++) begin
            drive(1, rb(10 + k), p6, 0, 0); tick();
            check("t6_offer", 1, 11 + k, (k == 0) ? 0 : 10 + k, k, 0);
            drive(1, '0, p6, 1, 0); tick(); check("t6_push", 0, 0, 11 + k, k + 1, 0);
            drive(1, '0, p6, 0, 0); tick(); check("t6_hold", 0, 0, 11 + k, k + 1, 0);
        end
        drive(1, rb(14), p6, 0, 0); tick(); check("t6_full",      0, 0, 14, 4, 0);
        drive(1, '0,     p6, 0, 0); tick(); check("t6_full_wait", 0, 0, 14, 4, 0);
        drive(1, '0,     p6, 0, 1); tick(); check("t6_reti",      0, 0, 13, 3, 0);
        drive(1, '0,     p6, 0, 0); tick(); check("t6_offer15",   1, 15, 13, 3, 0);
`else
        pd = pr(0, 0) | pr(1, 3);
        drive(1, rb(0), pd, 0, 0); tick(); check("nn_offer1", 1, 1, 0, 0, 0);
        drive(1, '0,    pd, 1, 0); tick(); check("nn_ack1",   0, 0, 1, 1, 0);
        drive(1, rb(1), pd, 0, 0); tick(); check("nn_hold",   0, 0, 1, 1, 0);
        drive(1, '0,    pd, 0, 0); tick(); check("nn_blocked", 0, 0, 1, 1, 0);
        tick();                            check("nn_blocked2", 0, 0, 1, 1, 0);
        drive(1, '0,    pd, 0, 1); tick(); check("nn_reti",   0, 0, 0, 0, 0);
        drive(1, '0,    pd, 0, 0); tick(); check("nn_offer2", 1, 2, 0, 0, 0);
`endif

        // Randomized traffic against the reference model.
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r_en  = ($urandom_range(7) != 0);
            r_req = '0;
            if ($urandom_range(2) == 0) r_req[$urandom_range(N_IRQ - 1)] = 1'b1;
            if ($urandom_range(5) == 0) r_req[$urandom_range(N_IRQ - 1)] = 1'b1;
            r_prio = prio_t'({$urandom, $urandom});
            r_ack  = 1'(($urandom_range(1)));
            r_reti = ($urandom_range(5) == 0);
            drive(r_en, r_req, r_prio, r_ack, r_reti);
            @(posedge clk);
            model_step(r_en, r_req, r_prio, r_ack, r_reti);
            #1;
            check("rand", moffer != 0, moffer, (mstk.size() > 0) ? mstk[$].id : 0,
                  mstk.size(), merr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
